mem_dma_initiator: RTL and testbench

MEM_DMA_INITIATOR -- requirements
Module: mem_dma_initiator

---
 rtl/mem_dma_initiator.sv | 164 ++++++++++++++++
 tb/tb_mem_dma_initiator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma_initiator.sv
// Memory-to-memory word copy engine: read one word, write it back out,
// repeat for len_words words, with bus-error and per-request timeout abort.
module mem_dma_initiator #(
    parameter int MEM_W       = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [15:0]        len_words,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    output logic               mem_we_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    output logic [MEM_W-1:0]   mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic               mem_err_i,
    input  logic [MEM_W-1:0]   mem_rdata_i
);

    localparam int BW = MEM_W / 8;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0]   STRIDE  = 32'(BW);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FIN,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      i_q, i_d;
    logic [MEM_W-1:0] buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [31:0]      offs;

    assign offs = 32'(i_q) * STRIDE;

    // State and datapath registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next state: a request is issued one cycle after entering RD/WR,
    // which leaves the mandatory idle bus cycle after every completion
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        done_d  = 1'b0;
        error_d = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len_words;
                    i_d     = '0;
                    error_d = 1'b0;
                    state_d = (len_words == 16'd0) ? S_FIN : S_RD;
                end
            end
            S_RD, S_WR: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    cnt_d = '0;
                end else if (mem_rvalid_i) begin
                    req_d = 1'b0;
                    if (mem_err_i) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (state_q == S_RD) begin
                        buf_d   = mem_rdata_i;
                        state_d = S_WR;
                    end else begin
                        i_d     = i_q + 16'd1;
                        state_d = (i_q + 16'd1 == len_q) ? S_FIN : S_RD;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1;
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus attributes follow the state, so they stay put while a request waits
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (state_q == S_RD) begin
            mem_addr_o = src_q + offs;
            mem_be_o   = '1;
        end else if (state_q == S_WR) begin
            mem_addr_o  = dst_q + offs;
            mem_we_o    = 1'b1;
            mem_be_o    = '1;
            mem_wdata_o = buf_q;
        end
    end

    assign busy      = (state_q == S_RD) || (state_q == S_WR) ||
                       (state_q == S_FIN);
    assign done      = done_q;
    assign error     = error_q;
    assign mem_req_o = req_q;

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Directed bench for mem_dma_initiator: copy, zero length, bus error,
// timeout, address wrap, ignored restart and mid-copy reset.
module tb_mem_dma_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic        mem_err_i;
    logic [31:0] mem_rdata_i;

    mem_dma_initiator #(
        .MEM_W(32),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .len_words(len_words),
        .busy(busy),
        .done(done),
        .error(error),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_err_i(mem_err_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // responder / monitor state
    logic        resp_en = 1'b1;
    logic        stray = 1'b0;
    int          err_at_read = 0;
    int          nreads = 0;
    int          req_cyc = 0;
    int          ndone = 0;
    int          viol_w = 0;
    int          viol_s = 0;
    logic [31:0] la[$];
    logic        lw[$];
    logic [31:0] ld[$];

    initial begin
        logic        p_req;
        logic        p_rv;
        logic        p_we;
        logic [31:0] p_addr;
        logic [31:0] p_wd;
        logic        rv;
        logic        er;
        logic [31:0] rd;
        p_req = 1'b0;
        p_rv = 1'b0;
        p_we = 1'b0;
        p_addr = '0;
        p_wd = '0;
        mem_rvalid_i = 1'b0;
        mem_err_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) req_cyc++;
            if (done) ndone++;
            if (!mem_we_o && mem_wdata_o != 32'd0) viol_w++;
            if (mem_req_o && p_req && !p_rv &&
                (mem_addr_o != p_addr || mem_we_o != p_we ||
                 mem_wdata_o != p_wd))
                viol_s++;
            p_req = mem_req_o;
            p_addr = mem_addr_o;
            p_we = mem_we_o;
            p_wd = mem_wdata_o;
            rv = 1'b0;
            er = 1'b0;
            rd = '0;
            if (mem_req_o && resp_en) begin
                rv = 1'b1;
                la.push_back(mem_addr_o);
                lw.push_back(mem_we_o);
                ld.push_back(mem_wdata_o);
                if (!mem_we_o) begin
                    nreads++;
                    rd = {mem_addr_o[15:0], ~mem_addr_o[15:0]};
                    er = (nreads == err_at_read);
                end
            end
            if (stray) rv = 1'b1;
            mem_rvalid_i = rv;
            mem_err_i = er;
            mem_rdata_i = rd;
            p_rv = rv;
        end
    end

    task automatic clear_log();
        la.delete();
        lw.delete();
        ld.delete();
        nreads = 0;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, output int cyc);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len_words = n;
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!(done || error) && cyc < 200);
        chk("wait_end", {31'b0, done | error}, 32'd1);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_req"}, {31'b0, mem_req_o}, 32'd0);
        chk({tag, "_we"}, {31'b0, mem_we_o}, 32'd0);
        chk({tag, "_be"}, {28'b0, mem_be_o}, 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;
        int r0;
        rst = 1'b1;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len_words = '0;
        repeat (3) @(negedge clk);
        chk_idle_outs("rst");
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, error}, 32'd0);
        rst = 1'b0;

        // three-word copy, one-cycle responder
        clear_log();
        d0 = ndone;
        run_copy(32'h1000, 32'h2000, 16'd3, cyc);
        chk("cp_cycles", 32'(cyc), 32'd14);
        chk("cp_done", {31'b0, done}, 32'd1);
        chk("cp_err", {31'b0, error}, 32'd0);
        chk("cp_n", 32'(la.size()), 32'd6);
        chk("cp_a0", la[0], 32'h0000_1000);
        chk("cp_w0", {31'b0, lw[0]}, 32'd0);
        chk("cp_a1", la[1], 32'h0000_2000);
        chk("cp_w1", {31'b0, lw[1]}, 32'd1);
        chk("cp_d1", ld[1], 32'h1000_EFFF);
        chk("cp_a2", la[2], 32'h0000_1004);
        chk("cp_a3", la[3], 32'h0000_2004);
        chk("cp_d3", ld[3], 32'h1004_EFFB);
        chk("cp_a4", la[4], 32'h0000_1008);
        chk("cp_a5", la[5], 32'h0000_2008);
        chk("cp_d5", ld[5], 32'h1008_EFF7);
        repeat (3) @(negedge clk);
        chk("cp_ndone", 32'(ndone - d0), 32'd1);

        // zero length
        r0 = req_cyc;
        d0 = ndone;
        run_copy(32'h1100, 32'h2100, 16'd0, cyc);
        chk("z_cycles", 32'(cyc), 32'd2);
        repeat (3) @(negedge clk);
        chk("z_req", 32'(req_cyc - r0), 32'd0);
        chk("z_ndone", 32'(ndone - d0), 32'd1);

        // bus error on the second read
        clear_log();
        err_at_read = 2;
        d0 = ndone;
        run_copy(32'h3000, 32'h4000, 16'd3, cyc);
        repeat (6) @(negedge clk);
        err_at_read = 0;
        chk("be_err", {31'b0, error}, 32'd1);
        chk("be_busy", {31'b0, busy}, 32'd0);
        chk("be_n", 32'(la.size()), 32'd3);
        chk("be_a2", la[2], 32'h0000_3004);
        chk("be_ndone", 32'(ndone - d0), 32'd0);
        chk("be_req", {31'b0, mem_req_o}, 32'd0);

        // silent responder, timeout of 8
        resp_en = 1'b0;
        r0 = req_cyc;
        d0 = ndone;
        run_copy(32'h5000, 32'h6000, 16'd2, cyc);
        repeat (3) @(negedge clk);
        resp_en = 1'b1;
        chk("to_req", 32'(req_cyc - r0), 32'd8);
        chk("to_err", {31'b0, error}, 32'd1);
        chk("to_busy", {31'b0, busy}, 32'd0);
        chk("to_ndone", 32'(ndone - d0), 32'd0);

        // source address wraps past 2^32
        clear_log();
        run_copy(32'hFFFF_FFFC, 32'h0000_0100, 16'd2, cyc);
        chk("wr_err", {31'b0, error}, 32'd0);
        chk("wr_n", 32'(la.size()), 32'd4);
        chk("wr_a0", la[0], 32'hFFFF_FFFC);
        chk("wr_a2", la[2], 32'h0000_0000);
        chk("wr_d3", ld[3], 32'h0000_FFFF);

        // stray completions in IDLE change nothing
        d0 = ndone;
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("st_busy", {31'b0, busy}, 32'd0);
        chk("st_req", {31'b0, mem_req_o}, 32'd0);
        chk("st_ndone", 32'(ndone - d0), 32'd0);

        // restart ignored while busy, then reset during a write
        clear_log();
        d0 = ndone;
        @(negedge clk);
        src_addr = 32'h5000;
        dst_addr = 32'h6000;
        len_words = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        src_addr = 32'h9000;
        dst_addr = 32'h9100;
        len_words = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(la.size() >= 3 && mem_we_o && mem_req_o) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rs_wait", {31'b0, mem_we_o & mem_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outs("rs");
        chk("rs_done", {31'b0, done}, 32'd0);
        chk("rs_a2", la[2], 32'h0000_5004);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ndone", 32'(ndone - d0), 32'd0);
        clear_log();
        run_copy(32'h7000, 32'h8000, 16'd1, cyc);
        chk("nw_cycles", 32'(cyc), 32'd6);
        chk("nw_n", 32'(la.size()), 32'd2);
        chk("nw_a1", la[1], 32'h0000_8000);
        chk("nw_d1", ld[1], 32'h7000_8FFF);

        repeat (2) @(negedge clk);
        chk("wdata_zero", 32'(viol_w), 32'd0);
        chk("req_stable", 32'(viol_s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
